// File: rtl/seg7_to_binary.sv
// -----------------------------------------------------------------------------
// seg7_to_binary
// Reads back three 7-segment digit patterns (hundreds, tens, units) and returns
// the 8-bit binary value they display. Fixed 4-cycle latency from the start
// edge to the valid pulse, including error cases.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      conversion request, sampled only in IDLE
//   seg_h/t/u  digit segments {a,b,c,d,e,f,g}, active-high
//   busy       high from the accepting edge until the valid edge
//   valid      one-cycle result pulse
//   value      converted result (0 on pattern error, 8'hFF on overflow)
//   err_seg    at least one digit pattern invalid
//   err_range  decoded number above 255
//   bad_digit  per-digit invalid flags {h,t,u}
// -----------------------------------------------------------------------------
module seg7_to_binary #(
    parameter bit ACCEPT_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] seg_h,
    input  logic [6:0] seg_t,
    input  logic [6:0] seg_u,
    output logic       busy,
    output logic       valid,
    output logic [7:0] value,
    output logic       err_seg,
    output logic       err_range,
    output logic [2:0] bad_digit
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned VAL_W = 8;
    localparam logic [ACC_W-1:0] VAL_MAX = ACC_W'(255);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_ACC1   = 3'd2,
        S_ACC2   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [SEG_W-1:0] seg_h_q, seg_h_d, seg_t_q, seg_t_d, seg_u_q, seg_u_d;
    logic [BCD_W-1:0] dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_u_q, dig_u_d;
    logic [2:0]       bad_q, bad_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             err_seg_q, err_seg_d;
    logic             err_range_q, err_range_d;
    logic [2:0]       bad_digit_q, bad_digit_d;

    // Exact-match pattern decode; returns {invalid, bcd}. Invalid maps to 0.
    function automatic logic [BCD_W:0] seg_decode(input logic [SEG_W-1:0] seg,
                                                  input logic blank_ok);
        logic [BCD_W:0] r;
        case (seg)
            7'b1111110: r = 5'b0_0000;
            7'b0110000: r = 5'b0_0001;
            7'b1101101: r = 5'b0_0010;
            7'b1111001: r = 5'b0_0011;
            7'b0110011: r = 5'b0_0100;
            7'b1011011: r = 5'b0_0101;
            7'b1011111: r = 5'b0_0110;
            7'b1110000: r = 5'b0_0111;
            7'b1111111: r = 5'b0_1000;
            7'b1111011: r = 5'b0_1001;
            7'b0000000: r = blank_ok ? 5'b0_0000 : 5'b1_0000;
            default:    r = 5'b1_0000;
        endcase
        return r;
    endfunction

    // x*10 as shift-and-add
    function automatic logic [ACC_W-1:0] times10(input logic [ACC_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seg_h_q     <= '0;
            seg_t_q     <= '0;
            seg_u_q     <= '0;
            dig_h_q     <= '0;
            dig_t_q     <= '0;
            dig_u_q     <= '0;
            bad_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            value_q     <= '0;
            err_seg_q   <= 1'b0;
            err_range_q <= 1'b0;
            bad_digit_q <= '0;
        end else begin
            state_q     <= state_d;
            seg_h_q     <= seg_h_d;
            seg_t_q     <= seg_t_d;
            seg_u_q     <= seg_u_d;
            dig_h_q     <= dig_h_d;
            dig_t_q     <= dig_t_d;
            dig_u_q     <= dig_u_d;
            bad_q       <= bad_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            value_q     <= value_d;
            err_seg_q   <= err_seg_d;
            err_range_q <= err_range_d;
            bad_digit_q <= bad_digit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DECODE;
            S_DECODE: state_d = S_ACC1;
            S_ACC1:   state_d = S_ACC2;
            S_ACC2:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        logic [BCD_W:0] dec_h, dec_t, dec_u;
        seg_h_d     = seg_h_q;
        seg_t_d     = seg_t_q;
        seg_u_d     = seg_u_q;
        dig_h_d     = dig_h_q;
        dig_t_d     = dig_t_q;
        dig_u_d     = dig_u_q;
        bad_d       = bad_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        value_d     = value_q;
        err_seg_d   = err_seg_q;
        err_range_d = err_range_q;
        bad_digit_d = bad_digit_q;
        dec_h       = seg_decode(seg_h_q, ACCEPT_BLANK);
        dec_t       = seg_decode(seg_t_q, ACCEPT_BLANK);
        dec_u       = seg_decode(seg_u_q, 1'b0);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seg_h_d = seg_h;
                    seg_t_d = seg_t;
                    seg_u_d = seg_u;
                    busy_d  = 1'b1;
                end
            end
            S_DECODE: begin
                dig_h_d = dec_h[BCD_W-1:0];
                dig_t_d = dec_t[BCD_W-1:0];
                dig_u_d = dec_u[BCD_W-1:0];
                bad_d   = {dec_h[BCD_W], dec_t[BCD_W], dec_u[BCD_W]};
            end
            S_ACC1: acc_d = times10(ACC_W'(dig_h_q)) + ACC_W'(dig_t_q);
            S_ACC2: acc_d = times10(acc_q) + ACC_W'(dig_u_q);
            S_DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                // Pattern errors take priority over range errors
                if (|bad_q) begin
                    value_d     = '0;
                    err_seg_d   = 1'b1;
                    err_range_d = 1'b0;
                    bad_digit_d = bad_q;
                end else if (acc_q > VAL_MAX) begin
                    value_d     = '1;
                    err_seg_d   = 1'b0;
                    err_range_d = 1'b1;
                    bad_digit_d = '0;
                end else begin
                    value_d     = acc_q[VAL_W-1:0];
                    err_seg_d   = 1'b0;
                    err_range_d = 1'b0;
                    bad_digit_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign value     = value_q;
    assign err_seg   = err_seg_q;
    assign err_range = err_range_q;
    assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_seg7_to_binary.sv
// -----------------------------------------------------------------------------
// tb_seg7_to_binary
// Directed bench for seg7_to_binary. Two instances share inputs: one with blank
// leading digits accepted, one with them rejected.
// -----------------------------------------------------------------------------
module tb_seg7_to_binary;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PB = 7'b0000000;
    localparam logic [6:0] PX = 7'b1010101;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] seg_h, seg_t, seg_u;
    logic       busy, valid, err_seg, err_range;
    logic [7:0] value;
    logic [2:0] bad_digit;
    logic       nb_busy, nb_valid, nb_err_seg, nb_err_range;
    logic [7:0] nb_value;
    logic [2:0] nb_bad_digit;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_to_binary #(.ACCEPT_BLANK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .seg_h(seg_h), .seg_t(seg_t), .seg_u(seg_u),
        .busy(busy), .valid(valid), .value(value),
        .err_seg(err_seg), .err_range(err_range), .bad_digit(bad_digit)
    );

    seg7_to_binary #(.ACCEPT_BLANK(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .start(start),
        .seg_h(seg_h), .seg_t(seg_t), .seg_u(seg_u),
        .busy(nb_busy), .valid(nb_valid), .value(nb_value),
        .err_seg(nb_err_seg), .err_range(nb_err_range), .bad_digit(nb_bad_digit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion: start at edge N, checks busy/valid each cycle, result at N+4.
    // noise=1 pulses start at N+1/N+2 and scrambles segment inputs while busy.
    task automatic conv(input string tag, input logic [6:0] h, input logic [6:0] t,
                        input logic [6:0] u, input logic [7:0] exp_val,
                        input logic exp_seg, input logic exp_rng,
                        input logic [2:0] exp_bad, input logic noise);
        seg_h = h; seg_t = t; seg_u = u; start = 1'b1;
        step();                                   // edge N
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".novalid"}, 32'(valid), 32'd0);
            if (noise) begin
                start = (i < 2);
                seg_h = P8; seg_t = P8; seg_u = PX;
            end
            step();                               // edges N+1..N+4
            start = 1'b0;
        end
        chk({tag, ".valid"}, 32'(valid), 32'd1);
        chk({tag, ".busy_lo"}, 32'(busy), 32'd0);
        chk({tag, ".value"}, 32'(value), 32'(exp_val));
        chk({tag, ".err_seg"}, 32'(err_seg), 32'(exp_seg));
        chk({tag, ".err_range"}, 32'(err_range), 32'(exp_rng));
        chk({tag, ".bad_digit"}, 32'(bad_digit), 32'(exp_bad));
        step();                                   // edge N+5
        chk({tag, ".pulse1"}, 32'(valid), 32'd0);
        chk({tag, ".hold"}, 32'(value), 32'(exp_val));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seg_h = '0; seg_t = '0; seg_u = '0;
        #2;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.value", 32'(value), 32'd0);
        chk("rst.err_seg", 32'(err_seg), 32'd0);
        chk("rst.err_range", 32'(err_range), 32'd0);
        chk("rst.bad_digit", 32'(bad_digit), 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        conv("v198", P1, P9, P8, 8'd198, 1'b0, 1'b0, 3'b000, 1'b0);
        conv("v255", P2, P5, P5, 8'd255, 1'b0, 1'b0, 3'b000, 1'b0);
        conv("v256", P2, P5, P6, 8'hFF, 1'b0, 1'b1, 3'b000, 1'b0);
        conv("v999", P9, P9, P9, 8'hFF, 1'b0, 1'b1, 3'b000, 1'b0);
        conv("blank", PB, PB, P5, 8'd5, 1'b0, 1'b0, 3'b000, 1'b0);
        chk("nb.value", 32'(nb_value), 32'd0);
        chk("nb.err_seg", 32'(nb_err_seg), 32'd1);
        chk("nb.err_range", 32'(nb_err_range), 32'd0);
        chk("nb.bad_digit", 32'(nb_bad_digit), 32'b110);
        conv("blank_u", P1, P2, PB, 8'd0, 1'b1, 1'b0, 3'b001, 1'b0);

        // Illegal tens digit; extra start pulses and input changes while busy
        conv("bad_t", P1, PX, P3, 8'd0, 1'b1, 1'b0, 3'b010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_requeue", 32'(valid), 32'd0);
        end
        conv("noisy_ok", P2, P0, P4, 8'd204, 1'b0, 1'b0, 3'b000, 1'b1);

        // start held high: valid at N+4, N+9, N+14 only
        seg_h = P1; seg_t = P2; seg_u = P3; start = 1'b1;
        step();                                   // edge N
        for (int i = 1; i <= 14; i++) begin
            step();
            chk($sformatf("held.valid%0d", i), 32'(valid), 32'((i % 5) == 4));
            if ((i % 5) == 4) chk("held.value", 32'(value), 32'd123);
        end
        start = 1'b0;
        step();

        // Asynchronous reset mid-conversion
        seg_h = P0; seg_t = P4; seg_u = P2; start = 1'b1;
        step();                                   // edge N
        start = 1'b0;
        step(); step();                           // edge N+2
        rst = 1'b1;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.value", 32'(value), 32'd0);
        chk("arst.valid", 32'(valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("arst.novalid", 32'(valid), 32'd0);
        end
        conv("post_rst", P0, P4, P2, 8'd42, 1'b0, 1'b0, 3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
